// File: rtl/note_word_classifier.sv
// note_word_classifier: collects note symbols into words, classifies each
// finished word, shows the last accepted symbol on a 7-segment display and
// counts emitted words.
module note_word_classifier #(
    parameter int unsigned NOTE_W     = 3,
    parameter int unsigned MAX_LEN    = 4,
    parameter int unsigned CLASS_MODE = 0
) (
    input  logic                             clk,
    input  logic                             Reset,
    input  logic                             in_valid,
    input  logic                             in_tom,
    input  logic [NOTE_W-1:0]                in_note,
    output logic                             in_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [1:0]                       out_type,
    output logic [$clog2(MAX_LEN+1)-1:0]     out_len,
    output logic                             out_ovf,
    output logic [6:0]                       seg,
    output logic [15:0]                      word_count
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned SYM_W = NOTE_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovf_q, ovf_d;
    logic [SYM_W-1:0]   buf_q [MAX_LEN];
    logic [SYM_W-1:0]   buf_d [MAX_LEN];

    logic               in_ready_d;
    logic               out_valid_d;
    logic [1:0]         out_type_d;
    logic [LEN_W-1:0]   out_len_d;
    logic               out_ovf_d;
    logic [6:0]         seg_d;
    logic [15:0]        word_count_d;

    logic [SYM_W-1:0]   sym_c;
    logic               accept_c;
    logic               is_term_c;
    logic [SYM_W-1:0]   last_sym_c;
    logic [1:0]         class_c;

    // Map one {tom, note} symbol to its word class.
    function automatic logic [1:0] map_sym(input logic [SYM_W-1:0] s);
        logic [1:0] r;
        r = 2'd0;
        if (s == {1'b0, NOTE_W'(3)})      r = 2'd3;
        else if (s == {1'b0, NOTE_W'(4)}) r = 2'd2;
        else if (s == {1'b0, NOTE_W'(5)}) r = 2'd1;
        return r;
    endfunction

    // Active-low hex digit decode, bit order g..a.
    function automatic logic [6:0] hex_seg(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'h0:    r = 7'b1000000;
            4'h1:    r = 7'b1111001;
            4'h2:    r = 7'b0100100;
            4'h3:    r = 7'b0110000;
            4'h4:    r = 7'b0011001;
            4'h5:    r = 7'b0010010;
            4'h6:    r = 7'b0000010;
            4'h7:    r = 7'b1111000;
            4'h8:    r = 7'b0000000;
            4'h9:    r = 7'b0010000;
            4'hA:    r = 7'b0001000;
            4'hB:    r = 7'b0000011;
            4'hC:    r = 7'b1000110;
            4'hD:    r = 7'b0100001;
            4'hE:    r = 7'b0000110;
            default: r = 7'b0001110;
        endcase
        return r;
    endfunction

    // Input symbol decode and classification of the word held in the buffer.
    always_comb begin
        sym_c      = {in_tom, in_note};
        accept_c   = in_valid && in_ready;
        is_term_c  = (in_note == '0);
        last_sym_c = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (LEN_W'(i + 1) == len_q) last_sym_c = buf_q[i];
        end
        class_c = 2'd0;
        if (!ovf_q) begin
            if (CLASS_MODE == 0) class_c = map_sym(last_sym_c);
            else if (len_q == LEN_W'(1)) class_c = map_sym(buf_q[0]);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        ovf_d        = ovf_q;
        buf_d        = buf_q;
        out_type_d   = out_type;
        out_len_d    = out_len;
        out_ovf_d    = out_ovf;
        seg_d        = seg;
        word_count_d = word_count;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (!is_term_c) begin
                        buf_d[0] = sym_c;
                        len_d    = LEN_W'(1);
                        ovf_d    = 1'b0;
                        state_d  = S_COLLECT;
                    end else begin
                        out_type_d = 2'd0;
                        out_len_d  = '0;
                        out_ovf_d  = 1'b0;
                        state_d    = S_EMIT;
                    end
                end
            end
            S_COLLECT: begin
                if (accept_c) begin
                    if (!is_term_c) begin
                        if (len_q < LEN_W'(MAX_LEN)) begin
                            for (int i = 0; i < int'(MAX_LEN); i++) begin
                                if (LEN_W'(i) == len_q) buf_d[i] = sym_c;
                            end
                            len_d = len_q + LEN_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        out_type_d = class_c;
                        out_len_d  = len_q;
                        out_ovf_d  = ovf_q;
                        state_d    = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    word_count_d = word_count + 16'd1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Display follows every accepted note; terminators leave it alone.
        if (accept_c && !is_term_c) seg_d = hex_seg(sym_c[3:0]);

        in_ready_d  = (state_d != S_EMIT);
        out_valid_d = (state_d == S_EMIT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < int'(MAX_LEN); i++) buf_q[i] <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_type   <= 2'd0;
            out_len    <= '0;
            out_ovf    <= 1'b0;
            seg        <= 7'b1111111;
            word_count <= 16'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ovf_q      <= ovf_d;
            for (int i = 0; i < int'(MAX_LEN); i++) buf_q[i] <= buf_d[i];
            in_ready   <= in_ready_d;
            out_valid  <= out_valid_d;
            out_type   <= out_type_d;
            out_len    <= out_len_d;
            out_ovf    <= out_ovf_d;
            seg        <= seg_d;
            word_count <= word_count_d;
        end
    end

endmodule

// File: tb/tb_note_word_classifier.sv
// Bench for note_word_classifier: two instances (last-symbol and
// single-symbol classification) share stimulus; a monitor checks each
// emitted word against a queue of hand-computed expectations.
module tb_note_word_classifier;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_tom;
    logic [2:0]  in_note;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_ovf0;
    logic [1:0]  out_type0;
    logic [2:0]  out_len0;
    logic [6:0]  seg0;
    logic [15:0] wc0;

    logic        in_ready1, out_valid1, out_ovf1;
    logic [1:0]  out_type1;
    logic [2:0]  out_len1;
    logic [6:0]  seg1;
    logic [15:0] wc1;

    typedef struct {
        logic [1:0] t0;
        logic [1:0] t1;
        logic [2:0] len;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wc_model = 0;

    note_word_classifier #(.NOTE_W(3), .MAX_LEN(4), .CLASS_MODE(0)) u0 (
        .clk(clk), .Reset(rst), .in_valid(in_valid), .in_tom(in_tom),
        .in_note(in_note), .in_ready(in_ready0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_type(out_type0), .out_len(out_len0),
        .out_ovf(out_ovf0), .seg(seg0), .word_count(wc0)
    );

    note_word_classifier #(.NOTE_W(3), .MAX_LEN(4), .CLASS_MODE(1)) u1 (
        .clk(clk), .Reset(rst), .in_valid(in_valid), .in_tom(in_tom),
        .in_note(in_note), .in_ready(in_ready1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_type(out_type1), .out_len(out_len1),
        .out_ovf(out_ovf1), .seg(seg1), .word_count(wc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare on every completed output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid0 && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(out_valid0), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("type_mode0", 32'(out_type0), 32'(e.t0));
                chk("len_mode0",  32'(out_len0),  32'(e.len));
                chk("ovf_mode0",  32'(out_ovf0),  32'(e.ovf));
                chk("valid_mode1", 32'(out_valid1), 32'd1);
                chk("type_mode1", 32'(out_type1), 32'(e.t1));
                chk("len_mode1",  32'(out_len1),  32'(e.len));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wc_model = 0;
    endtask

    task automatic send(input logic tom, input logic [2:0] note);
        in_valid = 1'b1;
        in_tom   = tom;
        in_note  = note;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Terminator with out_ready high: checks one-cycle latency, word retires.
    task automatic term(input logic [1:0] t0, input logic [1:0] t1,
                        input logic [2:0] len, input logic ovf);
        exp_t e;
        e.t0 = t0; e.t1 = t1; e.len = len; e.ovf = ovf;
        exp_q.push_back(e);
        send(1'b0, 3'd0);
        @(negedge clk);
        chk("latency_valid", 32'(out_valid0), 32'd1);
        @(posedge clk);
        #1;
        wc_model++;
        chk("word_count", 32'(wc0), 32'(wc_model));
        chk("back_idle_ready", 32'(in_ready0), 32'd1);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_tom = 1'b0; in_note = 3'd0; out_ready = 1'b1;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready0),  32'd1);
        chk("rst_out_valid", 32'(out_valid0), 32'd0);
        chk("rst_out_type",  32'(out_type0),  32'd0);
        chk("rst_out_len",   32'(out_len0),   32'd0);
        chk("rst_out_ovf",   32'(out_ovf0),   32'd0);
        chk("rst_seg",       32'(seg0),       32'h7F);
        chk("rst_wc",        32'(wc0),        32'd0);
        @(posedge clk); #1;

        // Single {0,3}
        send(1'b0, 3'd3);
        chk("seg_3", 32'(seg0), 32'b0110000);
        term(2'd3, 2'd3, 3'd1, 1'b0);

        // Last-symbol vs single-symbol classification
        send(1'b0, 3'd3); send(1'b0, 3'd4); send(1'b0, 3'd5);
        chk("seg_5", 32'(seg0), 32'b0010010);
        term(2'd1, 2'd0, 3'd3, 1'b0);

        send(1'b0, 3'd5); send(1'b0, 3'd3);
        term(2'd3, 2'd0, 3'd2, 1'b0);

        send(1'b1, 3'd4); send(1'b0, 3'd4);
        term(2'd2, 2'd0, 3'd2, 1'b0);

        send(1'b1, 3'd3);
        term(2'd0, 2'd0, 3'd1, 1'b0);

        // Overflow: six symbols into a four-deep word
        for (int i = 0; i < 6; i++) send(1'b0, 3'd4);
        term(2'd0, 2'd0, 3'd4, 1'b1);

        // Back-pressure hold for five cycles with offered symbols ignored
        begin
            exp_t e;
            e.t0 = 2'd1; e.t1 = 2'd1; e.len = 3'd1; e.ovf = 1'b0;
            exp_q.push_back(e);
        end
        send(1'b0, 3'd5);
        out_ready = 1'b0;
        in_valid = 1'b1; in_tom = 1'b0; in_note = 3'd0;
        @(posedge clk); #1;
        in_note = 3'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid0), 32'd1);
            chk("hold_ready", 32'(in_ready0),  32'd0);
            chk("hold_type",  32'(out_type0),  32'd1);
            chk("hold_len",   32'(out_len0),   32'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        wc_model++;
        chk("hold_release_ready", 32'(in_ready0),  32'd1);
        chk("hold_release_valid", 32'(out_valid0), 32'd0);
        chk("hold_seg_kept",      32'(seg0),       32'b0010010);
        chk("hold_wc",            32'(wc0),        32'(wc_model));

        // Terminator in IDLE right after reset
        do_reset();
        term(2'd0, 2'd0, 3'd0, 1'b0);
        chk("empty_seg", 32'(seg0), 32'h7F);

        // Reset mid-word discards the partial word
        send(1'b0, 3'd3); send(1'b0, 3'd4);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_valid_a", 32'(out_valid0), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wc_model = 0;
        @(negedge clk);
        chk("midreset_valid_b", 32'(out_valid0), 32'd0);
        chk("midreset_wc",      32'(wc0),        32'd0);
        @(posedge clk); #1;
        send(1'b1, 3'd3);
        chk("seg_b", 32'(seg0), 32'b0000011);
        term(2'd0, 2'd0, 3'd1, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("final_valid",   32'(out_valid0),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/note_word_classifier.md
NOTE_WORD_CLASSIFIER -- requirements
Module: note_word_classifier

Interface
REQ-001 Parameter NOTE_W, default 3, note-code width; SHALL be >= 3.
REQ-002 Parameter MAX_LEN, default 4, maximum symbols stored per word; SHALL be >= 1.
REQ-003 Parameter CLASS_MODE, default 0: 0 = classify by last symbol, 1 = classify single-symbol words only.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  input symbol present.
REQ-007 in_tom  in  1  tone bit of the symbol.
REQ-008 in_note  in  NOTE_W  note code; 0 is the word terminator.
REQ-009 in_ready  out  1  block accepts a symbol this cycle.
REQ-010 out_valid  out  1  classified word available.
REQ-011 out_ready  in  1  consumer takes the word.
REQ-012 out_type  out  2  word class: 3, 2, 1 = recognised word; 0 = invalid.
REQ-013 out_len  out  clog2(MAX_LEN+1)  number of stored symbols in the word.
REQ-014 out_ovf  out  1  word exceeded MAX_LEN symbols.
REQ-015 seg  out  7  active-low 7-segment display, seg[6]=g ... seg[0]=a.
REQ-016 word_count  out  16  count of emitted words.

Function
REQ-017 A symbol is accepted when in_valid and in_ready are both 1. A symbol is valid if in_note != 0; otherwise it is a terminator, regardless of in_tom.
REQ-018 States: IDLE, COLLECT, EMIT. in_ready SHALL be 1 in IDLE and COLLECT, and 0 in EMIT.
REQ-019 IDLE, valid symbol accepted: store it at index 0, set len=1, clear ovf, go to COLLECT.
REQ-020 IDLE, terminator accepted: go to EMIT with out_len=0, out_type=0, out_ovf=0.
REQ-021 COLLECT, valid symbol with len<MAX_LEN: append it and increment len.
REQ-022 COLLECT, valid symbol with len==MAX_LEN: discard the symbol, set ovf=1, keep len.
REQ-023 COLLECT, terminator accepted: go to EMIT next cycle.
REQ-024 Symbol map: {tom=0, note=3} -> 3; {0,4} -> 2; {0,5} -> 1; anything else -> 0. Constants are zero-extended to NOTE_W.
REQ-025 CLASS_MODE=0: out_type = map(last stored symbol).
REQ-026 CLASS_MODE=1: out_type = map(symbol 0) if len==1, else 0.
REQ-027 ovf=1 SHALL force out_type=0 in both modes.
REQ-028 EMIT: out_valid=1. out_type, out_len and out_ovf SHALL stay stable until out_ready=1. That cycle: return to IDLE and increment word_count (wrapping at 16 bits).
REQ-029 out_valid SHALL be 0 in IDLE and COLLECT. Data outputs hold their last values outside EMIT.
REQ-030 Latency: out_valid rises exactly 1 cycle after the terminator is accepted.
REQ-031 seg is registered and updates 1 cycle after each accepted valid symbol. It shows the standard hex digit of {in_tom, in_note}[3:0] (i.e. {in_tom,in_note} truncated to 4 bits). Terminators do not change seg.
REQ-032 in_valid=0 SHALL cause no state change.

Reset
REQ-033 Reset=1 at a clock edge SHALL force: state IDLE, in_ready=1, out_valid=0, out_type=0, out_len=0, out_ovf=0, seg=7'b1111111, word_count=0, buffer and len cleared.
REQ-034 Reset SHALL take priority over every other event, including mid-word and during EMIT. Partial words are discarded without being emitted.

Verification
REQ-035 Reset, then {0,3}, terminator, out_ready=1 -> out_valid the cycle after the terminator; out_type=3, out_len=1, seg=7'b0110000, word_count=1.
REQ-036 CLASS_MODE=0: {0,3},{0,4},{0,5}, terminator -> out_type=1, out_len=3. CLASS_MODE=1, same stimulus -> out_type=0.
REQ-037 MAX_LEN=4: six valid {0,4} symbols, then terminator -> out_len=4, out_ovf=1, out_type=0.
REQ-038 Emit with out_ready=0 for 5 cycles -> out_valid and data held, in_ready=0, offered symbols ignored; then out_ready=1 -> IDLE, in_ready=1.
REQ-039 Terminator in IDLE -> out_type=0, out_len=0; seg unchanged from 7'b1111111.
REQ-040 Reset asserted after {0,3},{0,4} (no terminator) -> no out_valid; then {1,3}, terminator -> out_type=0, out_len=1, seg=7'b0000011.
